flag_status_unit: RTL and testbench
===================================

// Module: flag_status_unit
// PURPOSE
//  Status register fed by the ALU flag generator: holds NZCV flags written when an
//  ALU op with S=1 retires. Evaluates 4-bit condition codes for the issue stage.
//  Keeps a small save stack so exception entry/return can preserve and restore
//  flags. The issue stage consumes cond_pass one cycle after it asks.
// PARAMETERS
//  STACK_DEPTH  4  saved-flag entries; power of 2, >=2
//  PTR_W        2  log2(STACK_DEPTH)
// PORTS
//  clk            in   1  clock, rising edge
//  rst            in   1  async reset, active-high
//  flag_we        in   1  ALU result with S=1 this cycle; load flags_in
//  flags_in       in   4  {N,Z,C,V} from flag generator
//  cond_valid     in   1  condition-check request
//  cond           in   4  condition code to evaluate
//  cond_out_valid out  1  cond_pass valid (1 cycle after cond_valid)
//  cond_pass      out  1  1 = condition true
//  push           in   1  exception entry: save current flags
//  pop            in   1  exception return: restore flags from stack top
//  err_clr        in   1  clear sticky err
//  flags_out      out  4  registered {N,Z,C,V}
//  stack_empty    out  1  sp==0
//  stack_full     out  1  sp==STACK_DEPTH
//  err            out  1  sticky: push when full or pop when empty
// BEHAVIOUR
//  Reset (async): flags_out=0, sp=0, stack_empty=1, stack_full=0, err=0,
//   cond_out_valid=0, cond_pass=0. Stack contents are don't-care.
//  Next flags (flags_d) priority, all per cycle:
//   - push&pop together: no-op on stack and err. flag_we still applies.
//   - pop, sp>0: flags_d = stack[sp-1]; sp--. flag_we the same cycle is dropped.
//   - pop, sp==0: err<=1; sp unchanged. flag_we applies if asserted.
//   - push, sp<DEPTH: stack[sp] = flags_out (pre-update value); sp++.
//     flag_we the same cycle still applies.
//   - push, sp==DEPTH: err<=1; stack unchanged; flag_we applies.
//   - else flag_we: flags_d=flags_in; otherwise hold.
//  sp is PTR_W+1 bits, range 0..DEPTH, no wrap. full/empty are registered from sp.
//  err: set has priority over err_clr in the same cycle.
//  Condition check: latency 1. cond_out_valid <= cond_valid.
//   cond_pass <= eval(cond, flags_d). This forwards same-cycle flag writes and pops.
//   cond_pass is held when cond_valid=0.
//  eval: 0 EQ Z; 1 NE !Z; 2 CS C; 3 CC !C; 4 MI N; 5 PL !N; 6 VS V; 7 VC !V;
//   8 HI C&!Z; 9 LS !C|Z; A GE N==V; B LT N!=V; C GT !Z&(N==V);
//   D LE Z|(N!=V); E AL 1; F NV 0 (reserved, never passes).
//  A back-to-back cond_valid every cycle is supported; there is no stall.
//  Reset mid-operation aborts the pending cond result (cond_out_valid=0 next edge).
// TESTING
//  1 flag_we, flags_in=4'b0100 -> flags_out=4'b0100 next cycle. cond=0 (EQ) -> pass=1.
//    cond=1 (NE) -> pass=0.
//  2 Same cycle: flag_we, flags_in=4'b1000, cond_valid, cond=4 (MI) -> next cycle
//    cond_out_valid=1, cond_pass=1 (bypass).
//  3 flags=4'b1001, cond=A (GE) -> pass=1. flags=4'b1000, cond=B (LT) -> pass=1.
//    cond=F -> 0. cond=E -> 1.
//  4 Push x4 with flags 1,2,3,4 -> stack_full=1. 5th push -> err=1, sp unchanged.
//    Pop x4 -> flags_out 4,3,2,1, stack_empty=1. Extra pop -> err stays 1.
//    err_clr -> err=0.
//  5 pop with flag_we (flags_in=4'hF), stack top=4'h2 -> flags_out=4'h2.
//    push with flag_we 4'h5 when flags=4'h3 -> stack top=4'h3, flags_out=4'h5.
//  6 Assert rst with cond_valid pending and sp=2 -> all outputs at reset values
//    asynchronously. cond_out_valid=0.

Source files
------------

// File: rtl/flag_status_unit.sv
// NZCV status register with condition-code evaluation and a small save stack
// used to preserve and restore flags across exception entry/return.
module flag_status_unit #(
  parameter int STACK_DEPTH = 4,
  parameter int PTR_W       = 2
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       flag_we,
  input  logic [3:0] flags_in,
  input  logic       cond_valid,
  input  logic [3:0] cond,
  output logic       cond_out_valid,
  output logic       cond_pass,
  input  logic       push,
  input  logic       pop,
  input  logic       err_clr,
  output logic [3:0] flags_out,
  output logic       stack_empty,
  output logic       stack_full,
  output logic       err
);

  localparam logic [PTR_W:0]   SP_FULL = (PTR_W+1)'(STACK_DEPTH);
  localparam logic [PTR_W:0]   SP_ZERO = '0;
  localparam logic [PTR_W:0]   SP_ONE  = (PTR_W+1)'(1);
  localparam logic [PTR_W-1:0] IDX_ONE = PTR_W'(1);

  logic [3:0]       stack_mem [STACK_DEPTH];
  logic [PTR_W:0]   sp;
  logic [PTR_W:0]   sp_d;
  logic [PTR_W-1:0] top_idx;
  logic [PTR_W-1:0] wr_idx;
  logic [3:0]       flags_d;
  logic             push_only;
  logic             pop_only;
  logic             push_ok;
  logic             pop_ok;
  logic             stack_err;

  function automatic logic eval_cond(input logic [3:0] code, input logic [3:0] f);
    logic n, z, c, v;
    logic result;
    n = f[3];
    z = f[2];
    c = f[1];
    v = f[0];
    result = 1'b0;
    case (code)
      4'h0:    result = z;
      4'h1:    result = !z;
      4'h2:    result = c;
      4'h3:    result = !c;
      4'h4:    result = n;
      4'h5:    result = !n;
      4'h6:    result = v;
      4'h7:    result = !v;
      4'h8:    result = c & !z;
      4'h9:    result = !c | z;
      4'hA:    result = (n == v);
      4'hB:    result = (n != v);
      4'hC:    result = !z & (n == v);
      4'hD:    result = z | (n != v);
      4'hE:    result = 1'b1;
      default: result = 1'b0;
    endcase
    return result;
  endfunction

  // Simultaneous push and pop cancel each other; only flag_we survives.
  assign push_only = push & !pop;
  assign pop_only  = pop & !push;
  assign push_ok   = push_only & (sp != SP_FULL);
  assign pop_ok    = pop_only & (sp != SP_ZERO);
  assign stack_err = (push_only & (sp == SP_FULL)) | (pop_only & (sp == SP_ZERO));

  // Low pointer bits wrap naturally, so sp==DEPTH still addresses the top entry.
  assign wr_idx  = sp[PTR_W-1:0];
  assign top_idx = sp[PTR_W-1:0] - IDX_ONE;

  always_comb begin
    flags_d = flags_out;
    sp_d    = sp;
    if (pop_ok) begin
      flags_d = stack_mem[top_idx];
      sp_d    = sp - SP_ONE;
    end else begin
      if (flag_we) begin
        flags_d = flags_in;
      end
      if (push_ok) begin
        sp_d = sp + SP_ONE;
      end
    end
  end

  // Saved entries need no reset; sp alone decides which ones are meaningful.
  always_ff @(posedge clk) begin
    if (push_ok) begin
      stack_mem[wr_idx] <= flags_out;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      flags_out   <= 4'h0;
      sp          <= SP_ZERO;
      stack_empty <= 1'b1;
      stack_full  <= 1'b0;
    end else begin
      flags_out   <= flags_d;
      sp          <= sp_d;
      stack_empty <= (sp_d == SP_ZERO);
      stack_full  <= (sp_d == SP_FULL);
    end
  end

  // A new stack error wins over a clear arriving in the same cycle.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      err <= 1'b0;
    end else if (stack_err) begin
      err <= 1'b1;
    end else if (err_clr) begin
      err <= 1'b0;
    end
  end

  // Evaluating against flags_d lets the issue stage see same-cycle writes and pops.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cond_out_valid <= 1'b0;
      cond_pass      <= 1'b0;
    end else begin
      cond_out_valid <= cond_valid;
      if (cond_valid) begin
        cond_pass <= eval_cond(cond, flags_d);
      end
    end
  end

endmodule

// File: tb/tb_flag_status_unit.sv
// Directed self-checking bench for flag_status_unit: flag writes, condition
// evaluation with bypass, save stack behaviour and asynchronous reset.
module tb_flag_status_unit;

  logic       clk;
  logic       rst;
  logic       flag_we;
  logic [3:0] flags_in;
  logic       cond_valid;
  logic [3:0] cond;
  logic       cond_out_valid;
  logic       cond_pass;
  logic       push;
  logic       pop;
  logic       err_clr;
  logic [3:0] flags_out;
  logic       stack_empty;
  logic       stack_full;
  logic       err;

  int compared;
  int mismatched;

  flag_status_unit #(.STACK_DEPTH(4), .PTR_W(2)) dut (
    .clk            (clk),
    .rst            (rst),
    .flag_we        (flag_we),
    .flags_in       (flags_in),
    .cond_valid     (cond_valid),
    .cond           (cond),
    .cond_out_valid (cond_out_valid),
    .cond_pass      (cond_pass),
    .push           (push),
    .pop            (pop),
    .err_clr        (err_clr),
    .flags_out      (flags_out),
    .stack_empty    (stack_empty),
    .stack_full     (stack_full),
    .err            (err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Inputs change and outputs are sampled 1ns after the rising edge.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    flag_we    = 1'b0;
    flags_in   = 4'h0;
    cond_valid = 1'b0;
    cond       = 4'h0;
    push       = 1'b0;
    pop        = 1'b0;
    err_clr    = 1'b0;
  endtask

  task automatic test_reset();
    idle_inputs();
    rst = 1'b1;
    tick();
    tick();
    compared++; if (flags_out !== 4'h0) begin mismatched++; $display("[TB] FAIL reset_flags: got %h expected %h", flags_out, 4'h0); end
    compared++; if (stack_empty !== 1'b1) begin mismatched++; $display("[TB] FAIL reset_empty: got %b expected 1", stack_empty); end
    compared++; if (stack_full !== 1'b0) begin mismatched++; $display("[TB] FAIL reset_full: got %b expected 0", stack_full); end
    compared++; if (err !== 1'b0) begin mismatched++; $display("[TB] FAIL reset_err: got %b expected 0", err); end
    compared++; if (cond_out_valid !== 1'b0) begin mismatched++; $display("[TB] FAIL reset_cov: got %b expected 0", cond_out_valid); end
    compared++; if (cond_pass !== 1'b0) begin mismatched++; $display("[TB] FAIL reset_pass: got %b expected 0", cond_pass); end
    rst = 1'b0;
    tick();
  endtask

  task automatic test_flag_write();
    flag_we  = 1'b1;
    flags_in = 4'b0100;
    tick();
    flag_we  = 1'b0;
    compared++; if (flags_out !== 4'b0100) begin mismatched++; $display("[TB] FAIL fw_flags: got %b expected 0100", flags_out); end
    cond_valid = 1'b1;
    cond       = 4'h1;
    tick();
    compared++; if (cond_out_valid !== 1'b1) begin mismatched++; $display("[TB] FAIL fw_cov: got %b expected 1", cond_out_valid); end
    compared++; if (cond_pass !== 1'b0) begin mismatched++; $display("[TB] FAIL fw_ne: got %b expected 0", cond_pass); end
    cond = 4'h0;
    tick();
    compared++; if (cond_pass !== 1'b1) begin mismatched++; $display("[TB] FAIL fw_eq: got %b expected 1", cond_pass); end
    cond_valid = 1'b0;
    cond       = 4'h1;
    tick();
    compared++; if (cond_out_valid !== 1'b0) begin mismatched++; $display("[TB] FAIL fw_cov_drop: got %b expected 0", cond_out_valid); end
    compared++; if (cond_pass !== 1'b1) begin mismatched++; $display("[TB] FAIL fw_pass_hold: got %b expected 1", cond_pass); end
  endtask

  task automatic test_bypass();
    flag_we    = 1'b1;
    flags_in   = 4'b1000;
    cond_valid = 1'b1;
    cond       = 4'h4;
    tick();
    compared++; if (cond_out_valid !== 1'b1) begin mismatched++; $display("[TB] FAIL byp_cov: got %b expected 1", cond_out_valid); end
    compared++; if (cond_pass !== 1'b1) begin mismatched++; $display("[TB] FAIL byp_mi: got %b expected 1", cond_pass); end
    compared++; if (flags_out !== 4'b1000) begin mismatched++; $display("[TB] FAIL byp_flags: got %b expected 1000", flags_out); end
    flags_in = 4'b0100;
    cond     = 4'h0;
    tick();
    compared++; if (cond_pass !== 1'b1) begin mismatched++; $display("[TB] FAIL byp_eq: got %b expected 1", cond_pass); end
    idle_inputs();
    tick();
  endtask

  // Back-to-back checks: every cycle loads new flags and evaluates a new code.
  task automatic test_conditions();
    logic [3:0] tbl_flags [14];
    logic [3:0] tbl_cond  [14];
    logic       tbl_exp   [14];
    tbl_flags = '{4'b1001, 4'b1000, 4'b1000, 4'b1000, 4'b0010, 4'b0110, 4'b0110,
                  4'b0000, 4'b0001, 4'b0001, 4'b0001, 4'b0000, 4'b1000, 4'b0000};
    tbl_cond  = '{4'hA, 4'hB, 4'hF, 4'hE, 4'h8, 4'h8, 4'h9,
                  4'hC, 4'hC, 4'hD, 4'h6, 4'h7, 4'h5, 4'h3};
    tbl_exp   = '{1'b1, 1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 1'b1,
                  1'b1, 1'b0, 1'b1, 1'b1, 1'b1, 1'b0, 1'b1};
    for (int i = 0; i < 14; i++) begin
      flag_we    = 1'b1;
      flags_in   = tbl_flags[i];
      cond_valid = 1'b1;
      cond       = tbl_cond[i];
      tick();
      compared++;
      if (cond_out_valid !== 1'b1 || cond_pass !== tbl_exp[i]) begin
        mismatched++;
        $display("[TB] FAIL cond_%0d (flags %b code %h): got valid %b pass %b expected valid 1 pass %b",
                 i, tbl_flags[i], tbl_cond[i], cond_out_valid, cond_pass, tbl_exp[i]);
      end
    end
    idle_inputs();
    tick();
  endtask

  task automatic test_stack();
    logic [3:0] exp_pop [4];
    exp_pop = '{4'h4, 4'h3, 4'h2, 4'h1};
    flag_we  = 1'b1;
    flags_in = 4'h1;
    tick();
    push = 1'b1;
    for (int i = 2; i <= 4; i++) begin
      flags_in = 4'(i);
      tick();
    end
    flag_we = 1'b0;
    tick();
    push = 1'b0;
    compared++; if (stack_full !== 1'b1 || stack_empty !== 1'b0) begin mismatched++; $display("[TB] FAIL stk_full: got full %b empty %b expected full 1 empty 0", stack_full, stack_empty); end
    compared++; if (err !== 1'b0) begin mismatched++; $display("[TB] FAIL stk_err_before: got %b expected 0", err); end
    compared++; if (flags_out !== 4'h4) begin mismatched++; $display("[TB] FAIL stk_flags4: got %h expected 4", flags_out); end
    push = 1'b1;
    tick();
    push = 1'b0;
    compared++; if (err !== 1'b1 || stack_full !== 1'b1) begin mismatched++; $display("[TB] FAIL stk_overflow: got err %b full %b expected err 1 full 1", err, stack_full); end
    pop = 1'b1;
    for (int i = 0; i < 4; i++) begin
      tick();
      compared++;
      if (flags_out !== exp_pop[i]) begin
        mismatched++;
        $display("[TB] FAIL stk_pop_%0d: got %h expected %h", i, flags_out, exp_pop[i]);
      end
    end
    compared++; if (stack_empty !== 1'b1 || stack_full !== 1'b0) begin mismatched++; $display("[TB] FAIL stk_empty: got empty %b full %b expected empty 1 full 0", stack_empty, stack_full); end
    tick();
    pop = 1'b0;
    compared++; if (err !== 1'b1 || flags_out !== 4'h1) begin mismatched++; $display("[TB] FAIL stk_underflow: got err %b flags %h expected err 1 flags 1", err, flags_out); end
    err_clr = 1'b1;
    tick();
    compared++; if (err !== 1'b0) begin mismatched++; $display("[TB] FAIL stk_err_clr: got %b expected 0", err); end
    pop = 1'b1;
    tick();
    pop     = 1'b0;
    compared++; if (err !== 1'b1) begin mismatched++; $display("[TB] FAIL stk_set_over_clr: got %b expected 1", err); end
    tick();
    err_clr = 1'b0;
    compared++; if (err !== 1'b0) begin mismatched++; $display("[TB] FAIL stk_err_clr2: got %b expected 0", err); end
  endtask

  task automatic test_stack_with_write();
    flag_we  = 1'b1;
    flags_in = 4'h2;
    tick();
    flag_we = 1'b0;
    push    = 1'b1;
    tick();
    push     = 1'b0;
    pop      = 1'b1;
    flag_we  = 1'b1;
    flags_in = 4'hF;
    tick();
    pop      = 1'b0;
    compared++; if (flags_out !== 4'h2 || stack_empty !== 1'b1) begin mismatched++; $display("[TB] FAIL pw_pop_drop_we: got flags %h empty %b expected flags 2 empty 1", flags_out, stack_empty); end
    flags_in = 4'h3;
    tick();
    push     = 1'b1;
    flags_in = 4'h5;
    tick();
    push    = 1'b0;
    flag_we = 1'b0;
    compared++; if (flags_out !== 4'h5 || stack_empty !== 1'b0) begin mismatched++; $display("[TB] FAIL pw_push_we: got flags %h empty %b expected flags 5 empty 0", flags_out, stack_empty); end
    pop = 1'b1;
    tick();
    pop = 1'b0;
    compared++; if (flags_out !== 4'h3) begin mismatched++; $display("[TB] FAIL pw_top: got %h expected 3", flags_out); end
    push     = 1'b1;
    pop      = 1'b1;
    flag_we  = 1'b1;
    flags_in = 4'h6;
    tick();
    idle_inputs();
    compared++; if (flags_out !== 4'h6 || stack_empty !== 1'b1 || err !== 1'b0) begin mismatched++; $display("[TB] FAIL pw_push_pop: got flags %h empty %b err %b expected flags 6 empty 1 err 0", flags_out, stack_empty, err); end
    flag_we  = 1'b1;
    flags_in = 4'b0100;
    tick();
    flag_we  = 1'b0;
    push     = 1'b1;
    tick();
    push     = 1'b0;
    flag_we  = 1'b1;
    flags_in = 4'b0000;
    tick();
    flag_we    = 1'b0;
    pop        = 1'b1;
    cond_valid = 1'b1;
    cond       = 4'h0;
    tick();
    idle_inputs();
    compared++; if (cond_pass !== 1'b1 || flags_out !== 4'b0100) begin mismatched++; $display("[TB] FAIL pw_pop_bypass: got pass %b flags %b expected pass 1 flags 0100", cond_pass, flags_out); end
  endtask

  task automatic test_async_reset();
    flag_we  = 1'b1;
    flags_in = 4'hA;
    push     = 1'b1;
    tick();
    flag_we = 1'b0;
    tick();
    push       = 1'b0;
    cond_valid = 1'b1;
    cond       = 4'hE;
    tick();
    compared++; if (cond_out_valid !== 1'b1 || cond_pass !== 1'b1 || stack_empty !== 1'b0) begin mismatched++; $display("[TB] FAIL ar_setup: got cov %b pass %b empty %b expected 1 1 0", cond_out_valid, cond_pass, stack_empty); end
    #2;
    rst = 1'b1;
    #1;
    compared++; if (cond_out_valid !== 1'b0 || cond_pass !== 1'b0) begin mismatched++; $display("[TB] FAIL ar_cond: got cov %b pass %b expected 0 0", cond_out_valid, cond_pass); end
    compared++; if (flags_out !== 4'h0 || stack_empty !== 1'b1 || stack_full !== 1'b0 || err !== 1'b0) begin mismatched++; $display("[TB] FAIL ar_state: got flags %h empty %b full %b err %b expected 0 1 0 0", flags_out, stack_empty, stack_full, err); end
    tick();
    compared++; if (cond_out_valid !== 1'b0) begin mismatched++; $display("[TB] FAIL ar_hold: got cov %b expected 0", cond_out_valid); end
    rst = 1'b0;
    idle_inputs();
    tick();
  endtask

  initial begin
    compared   = 0;
    mismatched = 0;
    rst        = 1'b1;
    idle_inputs();
    test_reset();
    test_flag_write();
    test_bypass();
    test_conditions();
    test_stack();
    test_stack_with_write();
    test_async_reset();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

  initial begin
    #100000;
    $display("[TB] FAIL timeout: got no completion expected completion");
    $fatal(1, "[TB] timeout");
  end

endmodule
